// File: rtl/me_pkg.sv
// Shared constants for the motion-estimator block loader: pixel width, memory geometry
// and loader state encoding.
package me_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned R_DIM   = 16;
    localparam int unsigned S_DIM   = 32;
    localparam int unsigned R_DEPTH = R_DIM * R_DIM;
    localparam int unsigned S_DEPTH = S_DIM * S_DIM;
    localparam int unsigned R_AW    = $clog2(R_DEPTH);
    localparam int unsigned S_AW    = $clog2(S_DEPTH);

    localparam logic [1:0] StLoadR = 2'd0;
    localparam logic [1:0] StLoadS = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;

endpackage

// File: rtl/me_pixel_ram.sv
// Pixel memory with one synchronous write port and NumRead asynchronous read ports.
// Contents are not reset.
module me_pixel_ram #(
    parameter int unsigned Width   = 8,
    parameter int unsigned Depth   = 256,
    parameter int unsigned NumRead = 1,
    localparam int unsigned Aw     = $clog2(Depth)
) (
    input  logic                            clk_i,
    input  logic                            we_i,
    input  logic [Aw-1:0]                   waddr_i,
    input  logic [Width-1:0]                wdata_i,
    input  logic [NumRead-1:0][Aw-1:0]      raddr_i,
    output logic [NumRead-1:0][Width-1:0]   rdata_o
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    for (genvar g = 0; g < NumRead; g++) begin : g_rd
        assign rdata_o[g] = mem[raddr_i[g]];
    end

endmodule

// File: rtl/me_block_loader.sv
// Streams pixels into the reference and search-window memories, then hands them to the
// motion estimator and captures its result as a one-cycle beat.
module me_block_loader
    import me_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_data,
    input  logic              in_sof,
    input  logic [R_AW-1:0]   AddressR,
    input  logic [S_AW-1:0]   AddressS1,
    input  logic [S_AW-1:0]   AddressS2,
    output logic [PIX_W-1:0]  R,
    output logic [PIX_W-1:0]  S1,
    output logic [PIX_W-1:0]  S2,
    output logic              Start,
    input  logic              completed,
    input  logic [3:0]        motionX,
    input  logic [3:0]        motionY,
    input  logic [7:0]        BestDist,
    output logic [3:0]        mv_x,
    output logic [3:0]        mv_y,
    output logic [7:0]        mv_dist,
    output logic              mv_valid,
    output logic              frame_err
);

    logic [1:0]      state_q, state_d;
    logic [S_AW-1:0] cnt_q, cnt_d;
    logic [3:0]      mv_x_q, mv_x_d, mv_y_q, mv_y_d;
    logic [7:0]      mv_dist_q, mv_dist_d;
    logic            mv_valid_q, mv_valid_d;
    logic            frame_err_q, frame_err_d;

    logic            accept;
    logic            r_we, s_we;
    logic [R_AW-1:0] r_waddr;

    assign in_ready = ~rst & (state_q != StRun);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mv_x_d      = mv_x_q;
        mv_y_d      = mv_y_q;
        mv_dist_d   = mv_dist_q;
        mv_valid_d  = 1'b0;
        frame_err_d = frame_err_q;
        r_we        = 1'b0;
        s_we        = 1'b0;
        r_waddr     = cnt_q[R_AW-1:0];
        case (state_q)
            StLoadR, StLoadS: begin
                if (accept) begin
                    // A stray start-of-frame restarts the load with this beat as R[0].
                    if (in_sof && (state_q == StLoadS || cnt_q != '0)) begin
                        r_we        = 1'b1;
                        r_waddr     = '0;
                        cnt_d       = S_AW'(1);
                        state_d     = StLoadR;
                        frame_err_d = 1'b1;
                    end else if (state_q == StLoadR) begin
                        r_we = 1'b1;
                        if (cnt_q == S_AW'(R_DEPTH - 1)) begin
                            cnt_d   = '0;
                            state_d = StLoadS;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        s_we = 1'b1;
                        if (cnt_q == S_AW'(S_DEPTH - 1)) begin
                            cnt_d   = '0;
                            state_d = StRun;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            StRun: begin
                if (completed) begin
                    mv_x_d     = motionX;
                    mv_y_d     = motionY;
                    mv_dist_d  = BestDist;
                    mv_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StLoadR;
                end
            end
            default: begin
                state_d = StLoadR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoadR;
            cnt_q       <= '0;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
            mv_dist_q   <= '0;
            mv_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mv_x_q      <= mv_x_d;
            mv_y_q      <= mv_y_d;
            mv_dist_q   <= mv_dist_d;
            mv_valid_q  <= mv_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign Start     = (state_q == StRun);
    assign mv_x      = mv_x_q;
    assign mv_y      = mv_y_q;
    assign mv_dist   = mv_dist_q;
    assign mv_valid  = mv_valid_q;
    assign frame_err = frame_err_q;

    me_pixel_ram #(
        .Width   (PIX_W),
        .Depth   (R_DEPTH),
        .NumRead (1)
    ) u_r_ram (
        .clk_i   (clk),
        .we_i    (r_we),
        .waddr_i (r_waddr),
        .wdata_i (in_data),
        .raddr_i (AddressR),
        .rdata_o (R)
    );

    me_pixel_ram #(
        .Width   (PIX_W),
        .Depth   (S_DEPTH),
        .NumRead (2)
    ) u_s_ram (
        .clk_i   (clk),
        .we_i    (s_we),
        .waddr_i (cnt_q),
        .wdata_i (in_data),
        .raddr_i ({AddressS2, AddressS1}),
        .rdata_o ({S2, S1})
    );

endmodule

// File: tb/tb_me_block_loader.sv
// Randomised bench for me_block_loader against a frame-position model of the pixel stream.
module tb_me_block_loader;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, in_sof, Start, completed, mv_valid, frame_err;
    logic [7:0] in_data, AddressR, R, S1, S2, BestDist, mv_dist;
    logic [9:0] AddressS1, AddressS2;
    logic [3:0] motionX, motionY, mv_x, mv_y;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a frame is 1280 beats; beat p lands in R[p] for p<256, else S[p-256].
    logic [7:0] ref_r [256];
    logic [7:0] ref_s [1024];
    int         pos;
    bit         running_exp, err_exp;
    logic [3:0] exp_x, exp_y;
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    me_block_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2),
        .R         (R),
        .S1        (S1),
        .S2        (S2),
        .Start     (Start),
        .completed (completed),
        .motionX   (motionX),
        .motionY   (motionY),
        .BestDist  (BestDist),
        .mv_x      (mv_x),
        .mv_y      (mv_y),
        .mv_dist   (mv_dist),
        .mv_valid  (mv_valid),
        .frame_err (frame_err)
    );

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        pos = 0; running_exp = 0; err_exp = 0;
        exp_x = '0; exp_y = '0; exp_d = '0;
    endtask

    // Feeds up to n beats (stops early if a frame completes); sof asserted when pos==sof_pos.
    task automatic drive_beats(input int n, input int sof_pos, input bit half, input bit ramp,
                               output int acc);
        int  cyc;
        bit  v;
        acc = 0; cyc = 0;
        sync();
        while (acc < n && !running_exp && cyc < 4 * n + 16) begin
            v        = half ? (cyc % 2 == 0) : 1'b1;
            in_valid = v;
            in_data  = ramp ? pos[7:0] : 8'($urandom);
            in_sof   = (sof_pos >= 0 && pos == sof_pos);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL load_in_ready: got %b expected 1 at pos %0d", in_ready, pos);
            end
            @(posedge clk);
            if (v) begin
                acc++;
                if (in_sof && pos != 0) begin
                    err_exp = 1; pos = 0;
                end
                if (pos < 256) ref_r[pos] = in_data;
                else ref_s[pos - 256] = in_data;
                pos++;
                if (pos == 1280) begin
                    running_exp = 1; pos = 0;
                end
            end
            #1;
            n_cmp++;
            if (Start !== running_exp) begin
                n_err++; $display("FAIL load_start: got %b expected %b after %0d accepts",
                                  Start, running_exp, acc);
            end
            n_cmp++;
            if (frame_err !== err_exp) begin
                n_err++; $display("FAIL load_frame_err: got %b expected %b", frame_err, err_exp);
            end
            cyc++;
        end
        in_valid = 0; in_sof = 0;
        if (acc < n && !running_exp) begin
            n_cmp++; n_err++;
            $display("FAIL load_timeout: got %0d accepts expected %0d", acc, n);
        end
    endtask

    task automatic check_mems(input string tag);
        for (int i = 0; i < 256; i++) begin
            AddressR = i[7:0];
            #1;
            n_cmp++;
            if (R !== ref_r[i]) begin
                n_err++; $display("FAIL %s R[%0d]: got %h expected %h", tag, i, R, ref_r[i]);
            end
        end
        for (int j = 0; j < 1024; j++) begin
            AddressS1 = j[9:0];
            AddressS2 = 10'($urandom_range(0, 1023));
            #1;
            n_cmp++;
            if (S1 !== ref_s[j]) begin
                n_err++; $display("FAIL %s S1[%0d]: got %h expected %h", tag, j, S1, ref_s[j]);
            end
            n_cmp++;
            if (S2 !== ref_s[AddressS2]) begin
                n_err++; $display("FAIL %s S2[%0d]: got %h expected %h", tag, AddressS2, S2,
                                  ref_s[AddressS2]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; in_sof = 0; in_data = 0; completed = 0;
        motionX = 0; motionY = 0; BestDist = 0; AddressR = 0; AddressS1 = 0; AddressS2 = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_cmp++;
        if (Start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b expected 0", Start); end
        n_cmp++;
        if ({mv_valid, mv_x, mv_y, mv_dist} !== 17'd0) begin
            n_err++; $display("FAIL rst_mv: got %b %h %h %h expected all 0", mv_valid, mv_x, mv_y, mv_dist);
        end
        n_cmp++;
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b expected 0", frame_err); end
        rst = 0;
        model_reset();
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_full_load();
        int acc;
        drive_beats(1280, 0, 0, 1, acc);
        n_cmp++;
        if (acc !== 1280) begin n_err++; $display("FAIL full_load_accepts: got %0d expected 1280", acc); end
        AddressR = 8'h2A; AddressS1 = 10'h3FF; AddressS2 = 10'h3FF;
        #1;
        n_cmp++;
        if (R !== 8'h2A) begin n_err++; $display("FAIL ramp_r2a: got %h expected 2a", R); end
        n_cmp++;
        if (S1 !== 8'hFF || S2 !== 8'hFF) begin
            n_err++; $display("FAIL ramp_s3ff: got %h/%h expected ff/ff", S1, S2);
        end
        check_mems("full_load");
    endtask

    task automatic test_run_hold();
        sync();
        for (int k = 0; k < 50; k++) begin
            in_valid = 1; in_data = 8'($urandom); in_sof = 1'($urandom);
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready: got %b expected 0", in_ready); end
            @(posedge clk);
            #1;
            n_cmp++;
            if (Start !== 1'b1) begin n_err++; $display("FAIL hold_start: got %b expected 1", Start); end
        end
        in_valid = 0; in_sof = 0;
        check_mems("run_hold");
    endtask

    task automatic test_result(input logic [3:0] x, input logic [3:0] y, input logic [7:0] d);
        sync();
        completed = 1; motionX = x; motionY = y; BestDist = d;
        @(posedge clk);
        #1;
        completed = 0; motionX = 4'($urandom); motionY = 4'($urandom); BestDist = 8'($urandom);
        if (running_exp) begin
            exp_x = x; exp_y = y; exp_d = d; running_exp = 0; pos = 0;
        end
        n_cmp++;
        if (mv_valid !== 1'b1) begin n_err++; $display("FAIL result_valid: got %b expected 1", mv_valid); end
        n_cmp++;
        if ({mv_x, mv_y, mv_dist} !== {exp_x, exp_y, exp_d}) begin
            n_err++; $display("FAIL result_mv: got %h,%h,%h expected %h,%h,%h",
                              mv_x, mv_y, mv_dist, exp_x, exp_y, exp_d);
        end
        n_cmp++;
        if (Start !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL result_ctrl: got start %b ready %b expected 0 1", Start, in_ready);
        end
        sync();
        n_cmp++;
        if (mv_valid !== 1'b0) begin n_err++; $display("FAIL result_pulse: got %b expected 0", mv_valid); end
        n_cmp++;
        if ({mv_x, mv_y, mv_dist} !== {exp_x, exp_y, exp_d}) begin
            n_err++; $display("FAIL result_hold: got %h,%h,%h expected %h,%h,%h",
                              mv_x, mv_y, mv_dist, exp_x, exp_y, exp_d);
        end
    endtask

    task automatic test_half_rate();
        int acc;
        drive_beats(1280, -1, 1, 0, acc);
        n_cmp++;
        if (acc !== 1280) begin n_err++; $display("FAIL half_rate_accepts: got %0d expected 1280", acc); end
        check_mems("half_rate");
    endtask

    task automatic test_completed_ignored();
        int acc;
        drive_beats(356, 0, 0, 0, acc);
        completed = 1; motionX = 4'($urandom); motionY = 4'($urandom); BestDist = 8'($urandom);
        @(posedge clk);
        #1;
        completed = 0;
        n_cmp++;
        if (mv_valid !== 1'b0) begin n_err++; $display("FAIL ignored_valid: got %b expected 0", mv_valid); end
        n_cmp++;
        if ({mv_x, mv_y, mv_dist} !== {exp_x, exp_y, exp_d}) begin
            n_err++; $display("FAIL ignored_mv: got %h,%h,%h expected %h,%h,%h",
                              mv_x, mv_y, mv_dist, exp_x, exp_y, exp_d);
        end
        n_cmp++;
        if (Start !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL ignored_ctrl: got start %b ready %b expected 0 1", Start, in_ready);
        end
    endtask

    task automatic test_sof_error();
        int acc;
        // Continue the partial frame up to S beat 500, which carries a stray sof.
        drive_beats(401, 756, 0, 0, acc);
        n_cmp++;
        if (frame_err !== 1'b1 || err_exp !== 1'b1) begin
            n_err++; $display("FAIL sof_err_flag: got %b expected 1", frame_err);
        end
        AddressR = 8'h00;
        #1;
        n_cmp++;
        if (R !== ref_r[0]) begin n_err++; $display("FAIL sof_err_r0: got %h expected %h", R, ref_r[0]); end
        drive_beats(1279, -1, 0, 0, acc);
        n_cmp++;
        if (acc !== 1279) begin n_err++; $display("FAIL sof_reload_accepts: got %0d expected 1279", acc); end
        check_mems("sof_reload");
    endtask

    task automatic test_reset_in_run();
        sync();
        n_cmp++;
        if (Start !== 1'b1 || frame_err !== 1'b1) begin
            n_err++; $display("FAIL pre_rst_state: got start %b err %b expected 1 1", Start, frame_err);
        end
        rst = 1; completed = 1; motionX = 4'hF; motionY = 4'hE; BestDist = 8'hDD;
        @(posedge clk);
        #1;
        rst = 0; completed = 0;
        model_reset();
        #1;
        n_cmp++;
        if (Start !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_run_ctrl: got start %b ready %b expected 0 1", Start, in_ready);
        end
        n_cmp++;
        if ({mv_valid, mv_x, mv_y, mv_dist} !== 17'd0) begin
            n_err++; $display("FAIL rst_run_mv: got %b %h %h %h expected all 0", mv_valid, mv_x, mv_y, mv_dist);
        end
        n_cmp++;
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_run_err: got %b expected 0", frame_err); end
        sync();
        n_cmp++;
        if (mv_valid !== 1'b0) begin n_err++; $display("FAIL rst_run_discard: got %b expected 0", mv_valid); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_run_hold();
        test_result(4'd3, 4'd12, 8'h5A);
        test_half_rate();
        test_result(4'($urandom), 4'($urandom), 8'($urandom));
        test_completed_ignored();
        test_sof_error();
        test_reset_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
